// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types, constants and helpers for the instruction
//               fetch queue (byte/size types, legal-advance-size check).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int MAX_INSTR_BYTES = 4;
    localparam int WORD_BYTES      = 4;

    typedef logic [7:0] byte_t;
    typedef logic [2:0] size_t;

    // The decoder may retire between 1 and MAX_INSTR_BYTES bytes per cycle.
    function automatic logic is_legal_size(input size_t size);
        return (size >= size_t'(1)) && (size <= size_t'(MAX_INSTR_BYTES));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_byte_ring.sv
`default_nettype none
// ============================================================================
// Module      : fetch_byte_ring
// Description : Circular byte buffer with a 4-byte masked write at the tail
//               and a combinational 4-byte read window at the head.
// Ports       : i_clk      - clock
//               i_reset    - synchronous active-low reset (pointers only)
//               i_clear    - return both pointers to zero (redirect)
//               i_wr_en    - write bytes i_wr_drop..3 of i_wr_data at tail
//               i_wr_data  - little-endian word, byte0 in [7:0]
//               i_wr_drop  - number of leading bytes of the word to skip
//               i_rd_adv   - retire i_rd_size bytes from the head
//               i_rd_size  - bytes to retire (1..4, checked by caller)
//               o_window   - bytes head..head+3, head byte in [7:0]
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_byte_ring
    import fetch_pkg::*;
#(
    parameter int DEPTH_BYTES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic [1:0]  i_wr_drop,
    input  logic        i_rd_adv,
    input  size_t       i_rd_size,
    output logic [31:0] o_window
);

    localparam int PTR_W = $clog2(DEPTH_BYTES);

    byte_t            buf_q [DEPTH_BYTES];
    byte_t            buf_d [DEPTH_BYTES];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    // Byte j of the incoming word lands at tail + (j - drop); bytes below
    // drop belong to addresses before the redirect target and are skipped.
    always_comb begin
        buf_d = buf_q;
        for (int j = 0; j < WORD_BYTES; j++) begin
            if (i_wr_en && (j >= int'(i_wr_drop))) begin
                buf_d[tail_q + PTR_W'(j) - PTR_W'(i_wr_drop)] = i_wr_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (i_clear) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (i_rd_adv) begin
                head_d = head_q + PTR_W'(i_rd_size);
            end
            if (i_wr_en) begin
                tail_d = tail_q + PTR_W'(3'd4 - {1'b0, i_wr_drop});
            end
        end
    end

    // Storage contents need no reset: nothing is visible until count says so.
    always_ff @(posedge i_clk) begin
        buf_q <= buf_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    generate
        for (genvar k = 0; k < WORD_BYTES; k++) begin : g_window
            assign o_window[8*k +: 8] = buf_q[head_q + PTR_W'(k)];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Byte queue between instruction memory and the x86 decoder.
//               Buffers fetched 32-bit words as bytes, presents a 4-byte
//               window at the current PC, retires 1-4 bytes per cycle and
//               supports redirect to an arbitrary byte address.
// Ports       : i_clk/i_reset          - clock, synchronous active-low reset
//               i_mem_data/i_mem_valid - fetched word for o_fetch_addr
//               o_mem_ready            - one word can be accepted this cycle
//               o_fetch_addr           - word address of next fetch
//               i_flush/i_flush_pc     - redirect request and target
//               o_window/o_window_valid/o_pc - decode window at PC
//               i_advance/i_advance_size     - decoder retires bytes
//               o_size_err             - pulse on illegal advance size
//               o_count                - bytes buffered
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH_BYTES = 16,
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [31:0]                  i_mem_data,
    input  logic                         i_mem_valid,
    output logic                         o_mem_ready,
    output logic [ADDR_W-1:0]            o_fetch_addr,
    input  logic                         i_flush,
    input  logic [ADDR_W-1:0]            i_flush_pc,
    output logic [31:0]                  o_window,
    output logic                         o_window_valid,
    output logic [ADDR_W-1:0]            o_pc,
    input  logic                         i_advance,
    input  logic [2:0]                   i_advance_size,
    output logic                         o_size_err,
    output logic [$clog2(DEPTH_BYTES):0] o_count
);

    localparam int CNT_W = $clog2(DEPTH_BYTES) + 1;
    localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC[ADDR_W-1:0];

    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [1:0]        drop_q, drop_d;
    logic              size_err_q, size_err_d;

    logic              mem_ready;
    logic              window_valid;
    logic              accept;
    logic              size_ok;
    logic              adv_legal;
    logic [CNT_W-1:0]  accept_bytes;

    // Ready depends only on registered occupancy, never on a same-cycle
    // advance, so the fill path has no combinational loop through the decoder.
    assign mem_ready    = ((CNT_W'(DEPTH_BYTES) - count_q) >= CNT_W'(4)) && !i_flush;
    assign window_valid = (count_q >= CNT_W'(4));
    assign accept       = i_mem_valid && mem_ready;
    assign size_ok      = is_legal_size(i_advance_size);
    assign adv_legal    = i_advance && window_valid && size_ok && !i_flush;
    assign accept_bytes = CNT_W'(3'd4 - {1'b0, drop_q});

    always_comb begin
        count_d      = count_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        drop_d       = drop_q;
        // An illegal size is reported even in a redirect cycle.
        size_err_d   = i_advance && window_valid && !size_ok;
        if (i_flush) begin
            count_d      = '0;
            pc_d         = i_flush_pc;
            fetch_addr_d = {i_flush_pc[ADDR_W-1:2], 2'b00};
            drop_d       = i_flush_pc[1:0];
        end else begin
            if (accept) begin
                fetch_addr_d = fetch_addr_q + ADDR_W'(4);
                drop_d       = 2'd0;
            end
            if (adv_legal) begin
                pc_d = pc_q + ADDR_W'(i_advance_size);
            end
            count_d = count_q + (accept ? accept_bytes : '0)
                              - (adv_legal ? CNT_W'(i_advance_size) : '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            count_q      <= '0;
            pc_q         <= RESET_PC_A;
            fetch_addr_q <= {RESET_PC_A[ADDR_W-1:2], 2'b00};
            drop_q       <= RESET_PC_A[1:0];
            size_err_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            drop_q       <= drop_d;
            size_err_q   <= size_err_d;
        end
    end

    fetch_byte_ring #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_ring (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (i_flush),
        .i_wr_en   (accept),
        .i_wr_data (i_mem_data),
        .i_wr_drop (drop_q),
        .i_rd_adv  (adv_legal),
        .i_rd_size (i_advance_size),
        .o_window  (o_window)
    );

    assign o_mem_ready    = mem_ready;
    assign o_fetch_addr   = fetch_addr_q;
    assign o_window_valid = window_valid;
    assign o_pc           = pc_q;
    assign o_size_err     = size_err_q;
    assign o_count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Self-checking bench for instr_fetch_queue. A byte-queue
//               scoreboard receives the bytes of every accepted word and
//               releases them on every legal advance; the DUT window, PC,
//               count and fetch address are checked against it each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int DEPTH = 16;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_mem_data;
    logic        i_mem_valid;
    logic        o_mem_ready;
    logic [31:0] o_fetch_addr;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic [31:0] o_window;
    logic        o_window_valid;
    logic [31:0] o_pc;
    logic        i_advance;
    logic [2:0]  i_advance_size;
    logic        o_size_err;
    logic [4:0]  o_count;

    instr_fetch_queue #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (32),
        .RESET_PC    (32'h0)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_mem_data     (i_mem_data),
        .i_mem_valid    (i_mem_valid),
        .o_mem_ready    (o_mem_ready),
        .o_fetch_addr   (o_fetch_addr),
        .i_flush        (i_flush),
        .i_flush_pc     (i_flush_pc),
        .o_window       (o_window),
        .o_window_valid (o_window_valid),
        .o_pc           (o_pc),
        .i_advance      (i_advance),
        .i_advance_size (i_advance_size),
        .o_size_err     (o_size_err),
        .o_count        (o_count)
    );

    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard and reference state
    logic [7:0]  sb_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    logic [1:0]  m_drop;
    logic        m_err;

    // Drive one cycle of stimulus, advance the reference model, and compare
    // every output against the scoreboard after the edge.
    task automatic step(input logic mv, input logic [31:0] md,
                        input logic fl, input logic [31:0] fpc,
                        input logic adv, input logic [2:0] sz);
        logic       exp_ready;
        logic       valid_before;
        logic       legal;
        logic [31:0] exp_win;
        i_mem_valid    = mv;
        i_mem_data     = md;
        i_flush        = fl;
        i_flush_pc     = fpc;
        i_advance      = adv;
        i_advance_size = sz;
        #1;
        exp_ready = ((DEPTH - sb_q.size()) >= 4) && !fl;
        vectors++;
        if (o_mem_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL mem_ready: got %b expected %b (count %0d)", o_mem_ready, exp_ready, sb_q.size());
        end
        valid_before = (sb_q.size() >= 4);
        legal        = (sz >= 3'd1) && (sz <= 3'd4);
        m_err        = adv && valid_before && !legal;
        if (fl) begin
            sb_q.delete();
            m_pc    = fpc;
            m_fetch = {fpc[31:2], 2'b00};
            m_drop  = fpc[1:0];
        end else begin
            if (adv && valid_before && legal) begin
                for (int i = 0; i < int'(sz); i++) void'(sb_q.pop_front());
                m_pc = m_pc + 32'(sz);
            end
            if (mv && exp_ready) begin
                for (int j = int'(m_drop); j < 4; j++) sb_q.push_back(md[8*j +: 8]);
                m_fetch = m_fetch + 32'd4;
                m_drop  = 2'd0;
            end
        end
        @(posedge i_clk);
        #1;
        vectors++;
        if (o_count !== 5'(sb_q.size())) begin
            miscompares++;
            $display("FAIL count: got %0d expected %0d", o_count, sb_q.size());
        end
        vectors++;
        if (o_pc !== m_pc) begin
            miscompares++;
            $display("FAIL pc: got %h expected %h", o_pc, m_pc);
        end
        vectors++;
        if (o_fetch_addr !== m_fetch) begin
            miscompares++;
            $display("FAIL fetch_addr: got %h expected %h", o_fetch_addr, m_fetch);
        end
        vectors++;
        if (o_size_err !== m_err) begin
            miscompares++;
            $display("FAIL size_err: got %b expected %b", o_size_err, m_err);
        end
        vectors++;
        if (o_window_valid !== (sb_q.size() >= 4)) begin
            miscompares++;
            $display("FAIL window_valid: got %b expected %b", o_window_valid, (sb_q.size() >= 4));
        end
        if (sb_q.size() >= 4) begin
            exp_win = {sb_q[3], sb_q[2], sb_q[1], sb_q[0]};
            vectors++;
            if (o_window !== exp_win) begin
                miscompares++;
                $display("FAIL window: got %h expected %h", o_window, exp_win);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd0);
    endtask

    task automatic test_reset();
        i_reset        = 1'b0;
        i_mem_valid    = 1'b1;
        i_mem_data     = 32'hDEADBEEF;
        i_flush        = 1'b0;
        i_flush_pc     = 32'h0;
        i_advance      = 1'b1;
        i_advance_size = 3'd2;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_mem_valid = 1'b0;
        i_advance   = 1'b0;
        sb_q.delete();
        m_pc    = 32'h0;
        m_fetch = 32'h0;
        m_drop  = 2'd0;
        m_err   = 1'b0;
        vectors++;
        if (o_count !== 5'd0 || o_pc !== 32'h0 || o_fetch_addr !== 32'h0 ||
            o_window_valid !== 1'b0 || o_size_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got count %0d pc %h fetch %h valid %b err %b expected 0 0 0 0 0",
                     o_count, o_pc, o_fetch_addr, o_window_valid, o_size_err);
        end
        i_reset = 1'b1;
    endtask

    task automatic test_first_word();
        step(1'b1, 32'h44332211, 1'b0, 32'h0, 1'b0, 3'd0);
        vectors++;
        if (o_window !== 32'h44332211 || o_pc !== 32'h0 || o_count !== 5'd4 || o_fetch_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL first_word: got win %h pc %h count %0d fetch %h expected 44332211 0 4 4",
                     o_window, o_pc, o_count, o_fetch_addr);
        end
        step(1'b1, 32'h88776655, 1'b0, 32'h0, 1'b1, 3'd1);
        vectors++;
        if (o_window !== 32'h55443322 || o_pc !== 32'h1 || o_count !== 5'd7) begin
            miscompares++;
            $display("FAIL accept_advance: got win %h pc %h count %0d expected 55443322 1 7",
                     o_window, o_pc, o_count);
        end
    endtask

    task automatic test_fill_and_wrap();
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA0A1A2A3 + 32'(i * 32'h04040404), 1'b0, 32'h0, 1'b0, 3'd0);
        vectors++;
        if (o_mem_ready !== 1'b0 || o_count !== 5'd15) begin
            miscompares++;
            $display("FAIL full: got ready %b count %0d expected 0 15", o_mem_ready, o_count);
        end
        // Advance while memory still offers a word: ready stays low this cycle.
        step(1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1, 3'd4);
        vectors++;
        if (o_mem_ready !== 1'b1 || o_count !== 5'd11) begin
            miscompares++;
            $display("FAIL ready_after_adv: got ready %b count %0d expected 1 11", o_mem_ready, o_count);
        end
        // Steady streaming pushes both pointers around the ring several times.
        for (int i = 0; i < 20; i++)
            step(1'b1, 32'h01020304 * 32'(i + 3), 1'b0, 32'h0, 1'b1, 3'(1 + (i % 4)));
    endtask

    task automatic test_unaligned_flush();
        step(1'b0, 32'h0, 1'b1, 32'h1002, 1'b0, 3'd0);
        vectors++;
        if (o_fetch_addr !== 32'h1000 || o_count !== 5'd0 || o_pc !== 32'h1002) begin
            miscompares++;
            $display("FAIL flush: got fetch %h count %0d pc %h expected 1000 0 1002", o_fetch_addr, o_count, o_pc);
        end
        step(1'b1, 32'hDDCCBBAA, 1'b0, 32'h0, 1'b0, 3'd0);
        vectors++;
        if (o_count !== 5'd2 || o_window_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_first: got count %0d valid %b expected 2 0", o_count, o_window_valid);
        end
        step(1'b1, 32'h11223344, 1'b0, 32'h0, 1'b0, 3'd0);
        vectors++;
        if (o_window !== 32'h3344DDCC || o_pc !== 32'h1002 || o_count !== 5'd6) begin
            miscompares++;
            $display("FAIL flush_second: got win %h pc %h count %0d expected 3344ddcc 1002 6", o_window, o_pc, o_count);
        end
    endtask

    task automatic test_size_err();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 3'd5);
        vectors++;
        if (o_size_err !== 1'b1 || o_pc !== 32'h1002 || o_count !== 5'd6 || o_window !== 32'h3344DDCC) begin
            miscompares++;
            $display("FAIL size5: got err %b pc %h count %0d win %h expected 1 1002 6 3344ddcc",
                     o_size_err, o_pc, o_count, o_window);
        end
        idle();
        vectors++;
        if (o_size_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse: got %b expected 0", o_size_err);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 3'd0);
        vectors++;
        if (o_size_err !== 1'b1 || o_count !== 5'd6) begin
            miscompares++;
            $display("FAIL size0: got err %b count %0d expected 1 6", o_size_err, o_count);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 3'd7);
        idle();
    endtask

    task automatic test_flush_priority();
        step(1'b1, 32'h99999999, 1'b1, 32'h20, 1'b1, 3'd2);
        vectors++;
        if (o_count !== 5'd0 || o_pc !== 32'h20 || o_fetch_addr !== 32'h20) begin
            miscompares++;
            $display("FAIL flush_prio: got count %0d pc %h fetch %h expected 0 20 20", o_count, o_pc, o_fetch_addr);
        end
        // Flush in the same cycle as an illegal advance still reports it.
        step(1'b1, 32'h03020100, 1'b0, 32'h0, 1'b0, 3'd0);
        step(1'b1, 32'h07060504, 1'b0, 32'h0, 1'b0, 3'd0);
        step(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 3'd6);
    endtask

    task automatic test_addr_wrap();
        step(1'b0, 32'h0, 1'b1, 32'hFFFFFFFE, 1'b0, 3'd0);
        step(1'b1, 32'hBBAA0000, 1'b0, 32'h0, 1'b0, 3'd0);
        step(1'b1, 32'h44332211, 1'b0, 32'h0, 1'b0, 3'd0);
        vectors++;
        if (o_window !== 32'h2211BBAA || o_fetch_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL addr_wrap: got win %h fetch %h expected 2211bbaa 4", o_window, o_fetch_addr);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 3'd4);
        vectors++;
        if (o_pc !== 32'h2) begin
            miscompares++;
            $display("FAIL pc_wrap: got %h expected 2", o_pc);
        end
    endtask

    task automatic test_random();
        logic [2:0] sz;
        logic       fl;
        for (int i = 0; i < 300; i++) begin
            fl = ($urandom_range(0, 19) == 0);
            sz = 3'($urandom_range(1, 4));
            // Illegal sizes only while the window is valid.
            if (sb_q.size() >= 4 && $urandom_range(0, 9) == 0) sz = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(5, 7));
            step(1'($urandom_range(0, 3) != 0), $urandom, fl, $urandom,
                 1'($urandom_range(0, 1)), sz);
        end
    endtask

    task automatic test_midstream_reset();
        step(1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0, 3'd0);
        step(1'b1, 32'h9ABCDEF0, 1'b1, 32'h77, 1'b1, 3'd2);
        test_reset();
        idle();
    endtask

    initial begin
        i_reset        = 1'b0;
        i_mem_valid    = 1'b0;
        i_mem_data     = 32'h0;
        i_flush        = 1'b0;
        i_flush_pc     = 32'h0;
        i_advance      = 1'b0;
        i_advance_size = 3'd0;
        test_reset();
        test_first_word();
        test_fill_and_wrap();
        test_unaligned_flush();
        test_size_err();
        test_flush_priority();
        test_addr_wrap();
        test_random();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
